// File: rtl/scoreboard_pkg.sv
// Shared definitions for the scoreboard game-clock / score controller and the
// display driver that consumes its outputs.
//   state_t   : controller state (PAUSED, RUN, EXPIRED)
//   SEC_MAX   : last seconds value before the minutes roll over
//   MIN_MAX   : last minutes value the game clock can show
//   cnt_width : bit width needed for a counter running 0..n-1 (never below 1)
package scoreboard_pkg;

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 99;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/score_timer_ctrl_if.sv
// Button / display bundle of the scoreboard controller.
//   reset_points, reset_score, one_point_t1, one_point_t2, pause : raw buttons
//   minutes[6:0], seconds[5:0] : binary game clock
//   t1[7:0], t2[7:0]           : binary team scores
//   running                    : high while the game clock runs
// master = button/display side, slave = controller side.
interface score_timer_ctrl_if;

    logic       reset_points;
    logic       reset_score;
    logic       one_point_t1;
    logic       one_point_t2;
    logic       pause;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic [7:0] t1;
    logic [7:0] t2;
    logic       running;

    modport master (
        output reset_points, reset_score, one_point_t1, one_point_t2, pause,
        input  minutes, seconds, t1, t2, running
    );

    modport slave (
        input  reset_points, reset_score, one_point_t1, one_point_t2, pause,
        output minutes, seconds, t1, t2, running
    );

endinterface

// File: rtl/score_timer_ctrl_btn_debounce.sv
// Raw push-button conditioner: 2-flop synchronizer, debouncer, rising-edge
// detector.
//   clock, reset : system clock, asynchronous active-low reset
//   btn          : raw, asynchronous button level
//   press        : one-cycle pulse per accepted press
// A new level is accepted after DEBOUNCE_CYCLES consecutive synchronized
// samples that differ from the current accepted level; any sample equal to
// the accepted level restarts the count.
module btn_debounce
    import scoreboard_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          level;
    logic          level_q;
    logic          armed;
    logic [CW-1:0] cnt;
    logic          ref_level;

    // Until a stable low has been seen after reset the button is presumed
    // held, so a button held through reset release cannot produce a press.
    assign ref_level = armed ? level : 1'b1;

    // NOTE: every register here is updated with <= so all of them sample the
    // pre-edge values; blocking assignments would let sync_q2 see the new
    // sync_q1 and silently collapse the synchronizer to one flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            armed   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            level_q <= level;
            if (sync_q2 == ref_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_q2;
                armed <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/score_timer_ctrl.sv
// Scoreboard game-clock and score controller.
//   clock, reset : system clock, asynchronous active-low reset
//   bus (slave)  : raw buttons in; minutes/seconds/t1/t2/running out
// Parameters: CLK_HZ (1 Hz prescaler period), DEBOUNCE_CYCLES (button
// debounce length), MAX_SCORE (score saturation value).
// Build option: define SCORE_LOCK_EN to accept score presses only while the
// clock runs; by default score presses are accepted in every state.
module score_timer_ctrl
    import scoreboard_pkg::*;
#(
    parameter int CLK_HZ          = 100000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_SCORE       = 99
) (
    input logic               clock,
    input logic               reset,
    score_timer_ctrl_if.slave bus
);

    localparam int            PW         = cnt_width(CLK_HZ);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [7:0]    SCORE_TOP  = 8'(MAX_SCORE);
    localparam logic [5:0]    SEC_TOP    = 6'(SEC_MAX);
    localparam logic [6:0]    MIN_TOP    = 7'(MIN_MAX);

    logic rp_pulse;
    logic rs_pulse;
    logic p1_pulse;
    logic p2_pulse;
    logic pause_pulse;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset_points (
        .clock(clock), .reset(reset), .btn(bus.reset_points), .press(rp_pulse)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset_score (
        .clock(clock), .reset(reset), .btn(bus.reset_score), .press(rs_pulse)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_point_t1 (
        .clock(clock), .reset(reset), .btn(bus.one_point_t1), .press(p1_pulse)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_point_t2 (
        .clock(clock), .reset(reset), .btn(bus.one_point_t2), .press(p2_pulse)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clock(clock), .reset(reset), .btn(bus.pause), .press(pause_pulse)
    );

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic [6:0]    minutes_q;
    logic [5:0]    seconds_q;
    logic [7:0]    t1_q;
    logic [7:0]    t2_q;
    logic          running_q;
    logic          tick;
    logic          at_limit;
    logic          score_en;

    assign tick     = (state == RUN) && (presc == PRESC_LAST);
    assign at_limit = (minutes_q == MIN_TOP) && (seconds_q == SEC_TOP);

`ifdef SCORE_LOCK_EN
    assign score_en = (state == RUN);
`else
    assign score_en = 1'b1;
`endif

    // NOTE: state_nxt gets its hold value before the case so every path
    // assigns it; a path that skipped the assignment would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            PAUSED: begin
                if (pause_pulse) state_nxt = RUN;
            end
            RUN: begin
                if (pause_pulse)                        state_nxt = PAUSED;
                else if (tick && at_limit && !rs_pulse) state_nxt = EXPIRED;
            end
            EXPIRED: begin
                if (rs_pulse) state_nxt = PAUSED;
            end
            default: state_nxt = PAUSED;
        endcase
    end

    // Game clock. A reset_score press wins over a coincident tick; a tick at
    // 99:59 leaves the clock frozen while the FSM moves to EXPIRED.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= PAUSED;
            running_q <= 1'b0;
            presc     <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
        end else begin
            state     <= state_nxt;
            running_q <= (state_nxt == RUN);
            if (rs_pulse) begin
                presc     <= '0;
                minutes_q <= '0;
                seconds_q <= '0;
            end else begin
                if (state == RUN) presc <= tick ? '0 : presc + PW'(1);
                if (tick && !at_limit) begin
                    if (seconds_q == SEC_TOP) begin
                        seconds_q <= '0;
                        minutes_q <= minutes_q + 7'd1;
                    end else begin
                        seconds_q <= seconds_q + 6'd1;
                    end
                end
            end
        end
    end

    // Team scores; reset_points overrides any coincident point press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            t1_q <= '0;
            t2_q <= '0;
        end else if (rp_pulse) begin
            t1_q <= '0;
            t2_q <= '0;
        end else if (score_en) begin
            if (p1_pulse && (t1_q < SCORE_TOP)) t1_q <= t1_q + 8'd1;
            if (p2_pulse && (t2_q < SCORE_TOP)) t2_q <= t2_q + 8'd1;
        end
    end

    assign bus.minutes = minutes_q;
    assign bus.seconds = seconds_q;
    assign bus.t1      = t1_q;
    assign bus.t2      = t2_q;
    assign bus.running = running_q;

endmodule

// File: tb/tb_score_timer_ctrl.sv
// Self-checking bench for score_timer_ctrl (CLK_HZ=10, DEBOUNCE_CYCLES=4).
// The reference model keeps elapsed game seconds and scores as plain integers;
// every expected display change is queued and a monitor compares each change
// of the DUT outputs against the head of the queue.
module tb_score_timer_ctrl;

    localparam int CLK_HZ    = 10;
    localparam int DEB       = 4;
    localparam int MAX_SCORE = 99;
    localparam int HOLD      = 10;
    localparam int GAP       = 10;

    localparam logic [4:0] B_RP    = 5'b00001;
    localparam logic [4:0] B_RS    = 5'b00010;
    localparam logic [4:0] B_T1    = 5'b00100;
    localparam logic [4:0] B_T2    = 5'b01000;
    localparam logic [4:0] B_PAUSE = 5'b10000;

`ifdef SCORE_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct packed {
        logic [6:0] minutes;
        logic [5:0] seconds;
        logic [7:0] t1;
        logic [7:0] t2;
        logic       running;
    } snap_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    score_timer_ctrl_if bus ();

    score_timer_ctrl #(
        .CLK_HZ(CLK_HZ),
        .DEBOUNCE_CYCLES(DEB),
        .MAX_SCORE(MAX_SCORE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int    errors = 0;
    int    checks = 0;
    snap_t exp_q[$];
    bit    mon_en = 1'b0;
    snap_t mon_last = '0;

    // Reference model: elapsed game seconds, scores, mode (0 paused, 1 run, 2 expired)
    int    m_secs = 0;
    int    m_t1 = 0;
    int    m_t2 = 0;
    int    m_mode = 0;
    snap_t m_pushed = '0;

    function automatic snap_t model_snap();
        snap_t s;
        s.minutes = 7'(m_secs / 60);
        s.seconds = 6'(m_secs % 60);
        s.t1      = 8'(m_t1);
        s.t2      = 8'(m_t2);
        s.running = (m_mode == 1);
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.minutes = bus.minutes;
        s.seconds = bus.seconds;
        s.t1      = bus.t1;
        s.t2      = bus.t2;
        s.running = bus.running;
        return s;
    endfunction

    task automatic check(input string name, input snap_t act, input snap_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d:%0d t1=%0d t2=%0d run=%0b, required %0d:%0d t1=%0d t2=%0d run=%0b",
                     name, act.minutes, act.seconds, act.t1, act.t2, act.running,
                     exp.minutes, exp.seconds, exp.t1, exp.t2, exp.running);
        end
    endtask

    task automatic push_model();
        snap_t s;
        s = model_snap();
        if (s != m_pushed) begin
            exp_q.push_back(s);
            m_pushed = s;
        end
    endtask

    task automatic model_press(input logic [4:0] m);
        if (m[0]) begin
            m_t1 = 0;
            m_t2 = 0;
        end else if (m_mode == 1 || !LOCK) begin
            if (m[2] && m_t1 < MAX_SCORE) m_t1++;
            if (m[3] && m_t2 < MAX_SCORE) m_t2++;
        end
        if (m[4] && m_mode != 2) m_mode = 1 - m_mode;
        if (m[1]) begin
            m_secs = 0;
            if (m_mode == 2) m_mode = 0;
        end
    endtask

    task automatic set_buttons(input logic [4:0] m);
        bus.reset_points = m[0];
        bus.reset_score  = m[1];
        bus.one_point_t1 = m[2];
        bus.one_point_t2 = m[3];
        bus.pause        = m[4];
    endtask

    task automatic drive(input logic [4:0] m, input bit bounce);
        if (bounce) begin
            for (int i = 0; i < 3; i++) begin
                set_buttons(m);
                repeat (2) @(negedge clock);
                set_buttons('0);
                repeat (2) @(negedge clock);
            end
        end
        set_buttons(m);
        repeat (HOLD) @(negedge clock);
        set_buttons('0);
        repeat (GAP) @(negedge clock);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d expected changes still pending, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic press(input logic [4:0] m, input bit bounce);
        model_press(m);
        push_model();
        drive(m, bounce);
        wait_drain(50, "press");
    endtask

    task automatic check_now(input string name);
        wait_drain(50, name);
        check(name, dut_snap(), model_snap());
    endtask

    // Start the clock, let it run n seconds (n >= 3), then pause it.
    task automatic run_secs(input int n);
        model_press(B_PAUSE);
        push_model();
        for (int i = 0; i < n; i++) begin
            m_secs++;
            push_model();
        end
        drive(B_PAUSE, 1'b0);
        wait_drain(n * CLK_HZ + 60, "run");
        press(B_PAUSE, 1'b0);
    endtask

    // Start the clock and let it run into the 99:59 limit.
    task automatic run_expire();
        int n;
        model_press(B_PAUSE);
        push_model();
        n = 0;
        while (m_secs < 99 * 60 + 59) begin
            m_secs++;
            n++;
            push_model();
        end
        m_mode = 2;
        push_model();
        drive(B_PAUSE, 1'b0);
        wait_drain((n + 1) * CLK_HZ + 60, "expire");
    endtask

    // Monitor: every change of the displayed outputs must match the next
    // expected change.
    always @(negedge clock) begin
        snap_t cur;
        if (mon_en) begin
            cur = dut_snap();
            if (cur !== mon_last) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change: got %0d:%0d t1=%0d t2=%0d run=%0b, required %0d:%0d t1=%0d t2=%0d run=%0b",
                             cur.minutes, cur.seconds, cur.t1, cur.t2, cur.running,
                             mon_last.minutes, mon_last.seconds, mon_last.t1, mon_last.t2, mon_last.running);
                end else begin
                    check("output_change", cur, exp_q.pop_front());
                end
                mon_last = cur;
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         r;
        logic [4:0] m;

        // Reset with one_point_t1 held high through reset release.
        set_buttons(B_T1);
        #1 reset = 1'b0;
        #2;
        check("reset_state", dut_snap(), model_snap());
        mon_en = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        set_buttons('0);
        repeat (15) @(negedge clock);
        check_now("held_through_reset");
        press(B_T1, 1'b0);

        // Bouncing press counts once.
        press(B_T1, 1'b1);
        check_now("bounce_single");

        // Random score presses, some bouncing.
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 2);
            m = (r == 0) ? B_T1 : (r == 1) ? B_T2 : (B_T1 | B_T2);
            press(m, $urandom_range(0, 1) == 1);
        end
        check_now("random_scores");

        // reset_points overrides a coincident point press at t1=12.
        press(B_RP, 1'b0);
        repeat (12) press(B_T1, 1'b0);
        press(B_RP | B_T1, 1'b0);
        check_now("reset_points_override");

        // Simultaneous presses from 5/7.
        repeat (5) press(B_T1, 1'b0);
        repeat (7) press(B_T2, 1'b0);
        press(B_T1 | B_T2, 1'b0);
        check_now("simultaneous_points");

        // Saturation at MAX_SCORE.
        press(B_RP, 1'b0);
        repeat (MAX_SCORE) press(B_T2, 1'b0);
        press(B_T2, 1'b0);
        check_now("t2_saturate");
        press(B_T1 | B_T2, 1'b0);
        check_now("t2_saturate_both");

        // Clock: one full minute from 00:00, then random run lengths.
        run_secs(60);
        check_now("one_minute");
        repeat (3) run_secs($urandom_range(3, 40));
        check_now("random_runs");

        // Run into 99:59, pause ignored, reset_score recovers.
        run_expire();
        check_now("expired");
        press(B_PAUSE, 1'b0);
        check_now("expired_pause_ignored");
        press(B_RS, 1'b0);
        check_now("reset_score_from_expired");

        // Asynchronous reset mid-run at 03:27.
        model_press(B_PAUSE);
        push_model();
        for (int i = 0; i < 207; i++) begin
            m_secs++;
            push_model();
        end
        drive(B_PAUSE, 1'b0);
        wait_drain(207 * CLK_HZ + 60, "run_to_0327");
        check("at_0327", dut_snap(), model_snap());
        reset = 1'b0;
        m_secs = 0;
        m_t1   = 0;
        m_t2   = 0;
        m_mode = 0;
        push_model();
        #1;
        check("async_reset", dut_snap(), model_snap());
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (12) @(negedge clock);
        check_now("after_async_reset");
        press(B_T1, 1'b0);
        check_now("press_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_timer_ctrl.md
SCORE_TIMER_CTRL -- requirements
Module: score_timer_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100000000, input clock frequency; sets the 1 Hz prescaler terminal count (CLK_HZ-1).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable synchronized samples before a button level is accepted (10 ms at 100 MHz).
REQ-003 Parameter MAX_SCORE, default 99, saturation value of each team score.
REQ-004 Port clock, input, 1, single system clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Ports reset_points and reset_score, input, 1 each, raw buttons; reset_points clears team scores, reset_score clears the game clock.
REQ-007 Ports one_point_t1 and one_point_t2, input, 1 each, raw buttons; each press adds one point to team 1 or team 2.
REQ-008 Port pause, input, 1, raw button; each press toggles run/pause.
REQ-009 Ports minutes [6:0] and seconds [5:0], output, binary game clock (0..99, 0..59) consumed by the 7-segment display driver.
REQ-010 Ports t1 [7:0] and t2 [7:0], output, binary team scores (0..MAX_SCORE) consumed by the display driver.
REQ-011 Port running, output, 1, high in state RUN only.

Function
REQ-012 Each raw button SHALL pass through a 2-flop synchronizer, then a debouncer, then a rising-edge detector producing a one-cycle press pulse.
REQ-013 Debouncer: accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples differing from the current accepted level; any bounce restarts the count.
REQ-014 Press pulse occurs the cycle after the accepted level goes 0->1; holding a button yields exactly one pulse.
REQ-015 State machine states: PAUSED, RUN, EXPIRED; reset state is PAUSED.
REQ-016 PAUSED + pause pulse -> RUN; RUN + pause pulse -> PAUSED; EXPIRED ignores pause pulse.
REQ-017 In RUN the prescaler counts 0..CLK_HZ-1; at terminal count it emits a one-cycle tick and wraps to 0; in PAUSED/EXPIRED the prescaler holds its value.
REQ-018 On tick: seconds 59 -> 0 with minutes+1, otherwise seconds+1.
REQ-019 On tick at 99:59, clock holds 99:59 and state -> EXPIRED in the same cycle.
REQ-020 reset_score pulse: minutes, seconds, prescaler -> 0 next cycle; EXPIRED -> PAUSED; RUN/PAUSED unchanged; takes priority over a coincident tick.
REQ-021 Score pulse: matching score +1 next cycle; at MAX_SCORE it holds.
REQ-022 Simultaneous t1 and t2 pulses both apply in the same cycle.
REQ-023 reset_points pulse clears t1 and t2 next cycle and overrides coincident score pulses.
REQ-024 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-025 reset low SHALL asynchronously force minutes=0, seconds=0, t1=0, t2=0, running=0, state PAUSED, prescaler 0, all synchronizer/debounce/edge registers 0.
REQ-026 Buttons held high during reset release yield no press pulse until released and pressed again.

Configuration
REQ-027 Macro SCORE_LOCK_EN defined: score pulses are ignored unless state is RUN.
REQ-028 Macro SCORE_LOCK_EN undefined: score pulses are accepted in every state.

Structure
REQ-029 Package scoreboard_pkg holds the state enumeration type (PAUSED, RUN, EXPIRED) and constants SEC_MAX=59 and MIN_MAX=99, shared with the display driver.
REQ-030 Sub-module btn_debounce (synchronizer + debouncer + edge detector, parameter DEBOUNCE_CYCLES), instantiated five times.

Verification (CLK_HZ=10, DEBOUNCE_CYCLES=4)
REQ-031 pause pressed 6 cycles -> running=1; after 10 cycles seconds=1; after 600 cycles minutes=1, seconds=0.
REQ-032 one_point_t1 bouncing 1-0-1 every 2 cycles then stable high 10 cycles -> t1 increments exactly once.
REQ-033 t2=99 (MAX_SCORE), one_point_t2 press -> t2 stays 99; simultaneous t1+t2 press from 5/7 -> 6/8.
REQ-034 Clock at 99:59 in RUN, next tick -> holds 99:59, running=0 (EXPIRED); pause press ignored; reset_score press -> 00:00, PAUSED.
REQ-035 reset_points and one_point_t1 pressed together with t1=12 -> t1=0; reset asserted mid-RUN at 03:27 -> all outputs 0 immediately, no clock edge needed.
REQ-036 SCORE_LOCK_EN defined, PAUSED, one_point_t1 press -> t1 unchanged; undefined -> t1+1.
